// File: rtl/tcp_session_price_decoder_pkg.sv
// Shared definitions for the TCP session price decoder: header flag masks,
// session state encodings and the ASCII digit range used by the converter.
package tcp_session_price_decoder_pkg;

    typedef enum logic [1:0] {
        ST_CLOSED      = 2'd0,
        ST_SYN_RCVD    = 2'd1,
        ST_ESTABLISHED = 2'd2
    } session_state_t;

    localparam logic [7:0] FLAG_SYN = 8'h01;
    localparam logic [7:0] FLAG_ACK = 8'h02;
    localparam logic [7:0] FLAG_FIN = 8'h04;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;

    function automatic logic is_ascii_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/tcp_session_price_decoder_if.sv
// Parsed-packet input bus and response-header output bus of the decoder.
// master = packet parser / transmitter side, slave = the session decoder.
interface tcp_session_price_decoder_if;

    logic        packet_ready;
    logic [7:0]  seq_num;
    logic [7:0]  ack_num;
    logic [7:0]  flags;
    logic [31:0] payload_data;

    logic        tx_valid;
    logic [7:0]  tx_seq;
    logic [7:0]  tx_ack;
    logic [7:0]  tx_flags;

    modport master (
        output packet_ready, seq_num, ack_num, flags, payload_data,
        input  tx_valid, tx_seq, tx_ack, tx_flags
    );

    modport slave (
        input  packet_ready, seq_num, ack_num, flags, payload_data,
        output tx_valid, tx_seq, tx_ack, tx_flags
    );

endinterface

// File: rtl/tcp_session_price_decoder_ascii_dec4_to_bin.sv
// Iterative four-digit ASCII to binary converter. One byte per cycle,
// most-significant digit first; value only updates on a clean conversion.
module ascii_dec4_to_bin
    import tcp_session_price_decoder_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        start,
    input  logic [31:0] payload,
    output logic        busy,
    output logic [13:0] value,
    output logic        done,
    output logic        err
);

    logic [31:0] payload_reg;
    logic [1:0]  idx_reg;
    logic        busy_reg;
    logic        bad_reg;
    logic        done_reg;
    logic        err_reg;
    logic [13:0] acc_reg;
    logic [13:0] value_reg;

    logic [7:0]  byte_arr [4];
    logic [7:0]  cur_byte;
    logic        cur_ok;
    logic        bad_next;
    logic [13:0] acc_next;

    // byte_arr[0] is the most-significant digit of the latched payload
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bytes
            assign byte_arr[gi] = payload_reg[31-8*gi -: 8];
        end
    endgenerate

    assign cur_byte = byte_arr[idx_reg];
    assign cur_ok   = is_ascii_digit(cur_byte);
    assign bad_next = bad_reg | ~cur_ok;
    // For '0'..'9' the low nibble is the digit value; garbage for other bytes is never committed
    assign acc_next = (acc_reg * 14'd10) + {10'd0, cur_byte[3:0]};

    // Latch payload on start, then fold in one digit per cycle for four cycles
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            payload_reg <= '0;
            idx_reg     <= '0;
            busy_reg    <= 1'b0;
            bad_reg     <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            acc_reg     <= '0;
            value_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            if (busy_reg) begin
                acc_reg <= acc_next;
                bad_reg <= bad_next;
                idx_reg <= idx_reg + 2'd1;
                if (idx_reg == 2'd3) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                    err_reg  <= bad_next;
                    if (!bad_next) begin
                        value_reg <= acc_next;
                    end
                end
            end else if (start) begin
                payload_reg <= payload;
                idx_reg     <= '0;
                acc_reg     <= '0;
                bad_reg     <= 1'b0;
                busy_reg    <= 1'b1;
            end
        end
    end

    assign busy  = busy_reg;
    assign value = value_reg;
    assign done  = done_reg;
    assign err   = err_reg;

endmodule

// File: rtl/tcp_session_price_decoder.sv
// Minimal TCP-like session tracker (handshake, in-order data, FIN) that
// acknowledges data packets and decodes their 4-digit ASCII price payload.
module tcp_session_price_decoder
    import tcp_session_price_decoder_pkg::*;
#(
    parameter logic [7:0] LOCAL_ISN = 8'h40
)
(
    input  logic                        CLK,
    input  logic                        RESET_N,
    tcp_session_price_decoder_if.slave  pkt,
    output logic [1:0]                  session_state,
    output logic [13:0]                 price,
    output logic                        price_valid,
    output logic                        price_error,
    output logic                        busy,
    output logic [7:0]                  drop_count
);

    localparam logic [7:0] LOCAL_ISN_P1 = LOCAL_ISN + 8'd1;

    session_state_t state_reg;
    logic [7:0]     expected_seq_reg;
    logic           tx_valid_reg;
    logic [7:0]     tx_seq_reg;
    logic [7:0]     tx_ack_reg;
    logic [7:0]     tx_flags_reg;
    logic [7:0]     drop_count_reg;

    logic [7:0]     drop_count_next;
    logic [7:0]     seq_plus1;
    logic           pkt_syn;
    logic           pkt_ack;
    logic           pkt_fin;
    logic           is_data;
    logic           in_order;
    logic           dec_start;
    logic           dec_busy;
    logic           dec_done;
    logic           dec_err;
    logic [13:0]    dec_value;

    assign pkt_syn   = |(pkt.flags & FLAG_SYN);
    assign pkt_ack   = |(pkt.flags & FLAG_ACK);
    assign pkt_fin   = |(pkt.flags & FLAG_FIN);
    assign is_data   = pkt_ack & ~pkt_syn & ~pkt_fin;
    assign in_order  = (pkt.seq_num == expected_seq_reg);
    assign seq_plus1 = pkt.seq_num + 8'd1;

    assign drop_count_next = (drop_count_reg == 8'hFF) ? 8'hFF : drop_count_reg + 8'd1;

    // An accepted in-order data packet kicks off the conversion in the same edge
    assign dec_start = pkt.packet_ready & ~dec_busy & (state_reg == ST_ESTABLISHED)
                     & is_data & in_order;

    ascii_dec4_to_bin u_dec (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .start   (dec_start),
        .payload (pkt.payload_data),
        .busy    (dec_busy),
        .value   (dec_value),
        .done    (dec_done),
        .err     (dec_err)
    );

    // Session FSM: classify each packet, emit the response header, count drops
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg        <= ST_CLOSED;
            expected_seq_reg <= '0;
            tx_valid_reg     <= 1'b0;
            tx_seq_reg       <= '0;
            tx_ack_reg       <= '0;
            tx_flags_reg     <= '0;
            drop_count_reg   <= '0;
        end else begin
            tx_valid_reg <= 1'b0;
            if (pkt.packet_ready) begin
                if (dec_busy) begin
                    drop_count_reg <= drop_count_next;
                end else begin
                    case (state_reg)
                        ST_CLOSED: begin
                            if (pkt_syn) begin
                                expected_seq_reg <= seq_plus1;
                                tx_valid_reg     <= 1'b1;
                                tx_flags_reg     <= FLAG_SYN | FLAG_ACK;
                                tx_seq_reg       <= LOCAL_ISN;
                                tx_ack_reg       <= seq_plus1;
                                state_reg        <= ST_SYN_RCVD;
                            end else begin
                                drop_count_reg <= drop_count_next;
                            end
                        end
                        ST_SYN_RCVD: begin
                            if (pkt_syn) begin
                                // Peer missed our SYN-ACK: resend it unchanged
                                tx_valid_reg <= 1'b1;
                                tx_flags_reg <= FLAG_SYN | FLAG_ACK;
                                tx_seq_reg   <= LOCAL_ISN;
                                tx_ack_reg   <= expected_seq_reg;
                            end else if (pkt_ack && (pkt.ack_num == LOCAL_ISN_P1) && in_order) begin
                                state_reg <= ST_ESTABLISHED;
                            end else begin
                                drop_count_reg <= drop_count_next;
                            end
                        end
                        ST_ESTABLISHED: begin
                            if (pkt_syn) begin
                                drop_count_reg <= drop_count_next;
                            end else if (pkt_fin) begin
                                tx_valid_reg     <= 1'b1;
                                tx_flags_reg     <= FLAG_ACK | FLAG_FIN;
                                tx_seq_reg       <= LOCAL_ISN_P1;
                                tx_ack_reg       <= seq_plus1;
                                expected_seq_reg <= '0;
                                state_reg        <= ST_CLOSED;
                            end else if (is_data) begin
                                tx_valid_reg <= 1'b1;
                                tx_flags_reg <= FLAG_ACK;
                                tx_seq_reg   <= LOCAL_ISN_P1;
                                if (in_order) begin
                                    expected_seq_reg <= seq_plus1;
                                    tx_ack_reg       <= seq_plus1;
                                end else begin
                                    // Out-of-order: duplicate ACK of what we still expect
                                    tx_ack_reg     <= expected_seq_reg;
                                    drop_count_reg <= drop_count_next;
                                end
                            end else begin
                                drop_count_reg <= drop_count_next;
                            end
                        end
                        default: begin
                            state_reg <= ST_CLOSED;
                        end
                    endcase
                end
            end
        end
    end

    assign pkt.tx_valid = tx_valid_reg;
    assign pkt.tx_seq   = tx_seq_reg;
    assign pkt.tx_ack   = tx_ack_reg;
    assign pkt.tx_flags = tx_flags_reg;

    assign session_state = state_reg;
    assign price         = dec_value;
    assign price_valid   = dec_done & ~dec_err;
    assign price_error   = dec_err;
    assign busy          = dec_busy;
    assign drop_count    = drop_count_reg;

endmodule
